gray_counter: RTL
=================

Name: gray_counter

Overview:
Parametrised up/down counter that keeps its state in binary and presents registered binary and Gray-coded outputs.
- Loadable from a Gray-coded value; the load path uses an internal Gray-to-binary conversion.
- Used as the pointer/sequence generator for clock-domain-crossing structures, where only one output bit may change per count step.
- Generalises the standalone combinational Gray-to-binary converter into a sequential, WIDTH-parametrised block.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- RST_VAL, 0, binary count value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  load request; takes priority over en.
- load_gray  input  WIDTH  value to load, in Gray code.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray count, equal to bin_out ^ (bin_out >> 1).
- tc  output  1  terminal count, combinational from registered state and up_dn.
- wrap  output  1  registered single-cycle pulse marking a wrap.

Behaviour:
- Single clock domain: clk. Reset: rst, synchronous, active-high, sampled on the rising edge of clk.
- Reset:
  - bin_out = RST_VAL.
  - gray_out = RST_VAL ^ (RST_VAL >> 1).
  - wrap = 0.
  - rst overrides load and en in the same cycle.
- Priority per cycle: rst > load > en > hold.
- Load:
  - bin_next[WIDTH-1] = load_gray[WIDTH-1].
  - bin_next[i] = bin_next[i+1] ^ load_gray[i], for i = WIDTH-2 down to 0.
  - gray_out next equals load_gray exactly.
  - wrap next = 0.
- Count (en=1, load=0):
  - bin_next = bin_out + 1 if up_dn = 1, else bin_out - 1, modulo 2^WIDTH.
  - gray_out next = bin_next ^ (bin_next >> 1).
- Hold (en=0, load=0): all registers keep their value; wrap next = 0.
- Latency: outputs update on the clock edge after the control inputs are sampled (1 cycle). bin_out and gray_out always update on the same edge.
- Gray property: on every count step exactly one bit of gray_out toggles, including across a wrap. A load may change any number of bits.
- tc:
  - tc = 1 when up_dn = 1 and bin_out = 2^WIDTH-1.
  - tc = 1 when up_dn = 0 and bin_out = 0.
  - Otherwise tc = 0. tc is independent of en.
- wrap:
  - Asserted for one cycle on the edge at which the count steps from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
  - In other words, wrap next = tc & en & ~load.
  - Consecutive wraps, for example when WIDTH is small, produce back-to-back pulses.
- Direction change: up_dn may change in any cycle. The step direction is the value sampled on that edge; no bubble.
- Simultaneous load and en: load wins and no step is taken.
- Reset mid-count: reset takes effect on the next edge regardless of en, load or up_dn; wrap is cleared.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: GRAY_CNT_SAT_EN.
- When defined, the counter saturates instead of wrapping.
  - With en=1 and tc=1, bin_out and gray_out hold their value.
  - wrap pulses for one cycle to flag the blocked step (wrap next = tc & en & ~load).
  - Load and reset behaviour is unchanged.
- When undefined, the counter wraps modulo 2^WIDTH as described in Behaviour.

Test Plan (all scenarios use WIDTH=4, RST_VAL=0):
- Reset: hold rst=1 for 2 cycles with en=1 and load=1 -> bin_out=0x0, gray_out=0x0, wrap=0. With up_dn=0, tc=1.
- Load conversion: load=1 with load_gray=0xC -> next cycle bin_out=0x8, gray_out=0xC. Then load_gray=0xF -> bin_out=0xA, gray_out=0xF. Then load_gray=0x0 -> bin_out=0x0.
- Up count and wrap: load 0x8 (Gray of binary 0xF), then en=1, up_dn=1 -> bin_out 0xF->0x0, gray_out 0x8->0x0, wrap=1 for exactly one cycle. The bench checks that each step toggles exactly one gray_out bit over 20 steps.
- Down count and wrap: from bin_out=0x0, en=1, up_dn=0 -> bin_out=0xF, gray_out=0x8, wrap pulse. The next step gives 0xE/0x9 with wrap=0.
- Priority and hold:
  - load=1 and en=1 with load_gray=0x7 -> bin_out=0x5 with no extra step.
  - Then en=0 for 3 cycles -> values hold.
  - Then flip up_dn every cycle with en=1 -> bin_out alternates 0x6, 0x5, 0x6.
- Saturate (GRAY_CNT_SAT_EN defined): from bin_out=0xE, en=1, up_dn=1 for 3 cycles -> bin_out 0xF, 0xF, 0xF. wrap=1 on the 2nd and 3rd edges; gray_out stays 0x8.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter that also presents its count in Gray code, and can be loaded from a Gray value.
// Define GRAY_CNT_SAT_EN to make the counter stop at its end values instead of wrapping.
module gray_counter #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic             tc_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] bin_next_s;
    logic [WIDTH-1:0] gray_next_s;
    logic             wrap_next_s;

    // Terminal count: the next step in the requested direction would wrap.
    always_comb begin
        tc_s = 1'b0;
        if (up_dn) begin
            tc_s = (bin_r == MAX_VAL);
        end else begin
            tc_s = (bin_r == ZERO_VAL);
        end
    end

    // Value reached by one count step; saturating builds stay put at the end values.
    always_comb begin
        step_s = bin_r;
`ifdef GRAY_CNT_SAT_EN
        if (tc_s) begin
            step_s = bin_r;
        end else if (up_dn) begin
            step_s = bin_r + ONE_VAL;
        end else begin
            step_s = bin_r - ONE_VAL;
        end
`else
        if (up_dn) begin
            step_s = bin_r + ONE_VAL;
        end else begin
            step_s = bin_r - ONE_VAL;
        end
`endif
    end

    // Next-state selection with priority load > en > hold.
    always_comb begin
        bin_next_s  = bin_r;
        gray_next_s = gray_r;
        wrap_next_s = 1'b0;
        case ({load, en})
            2'b10, 2'b11: begin
                bin_next_s  = gray_to_bin(load_gray);
                gray_next_s = load_gray;
                wrap_next_s = 1'b0;
            end
            2'b01: begin
                bin_next_s  = step_s;
                gray_next_s = bin_to_gray(step_s);
                wrap_next_s = tc_s;
            end
            2'b00: begin
                bin_next_s  = bin_r;
                gray_next_s = gray_r;
                wrap_next_s = 1'b0;
            end
            default: begin
                bin_next_s  = bin_r;
                gray_next_s = gray_r;
                wrap_next_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= RST_VAL;
            gray_r <= bin_to_gray(RST_VAL);
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_next_s;
            gray_r <= gray_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign bin_out  = bin_r;
    assign gray_out = gray_r;
    assign wrap     = wrap_r;
    assign tc       = tc_s;

endmodule
